// File: rtl/uart_lite_pkg.sv
// Shared definitions for the uart_lite block: register map, STATUS layout,
// response codes, divider floor and the serial FSM state encoding.
package uart_lite_pkg;

    // Register word index, taken from addr[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    // STATUS register bit positions
    localparam int unsigned STAT_TX_FULL      = 0;
    localparam int unsigned STAT_TX_EMPTY     = 1;
    localparam int unsigned STAT_TX_BUSY      = 2;
    localparam int unsigned STAT_RX_VALID     = 3;
    localparam int unsigned STAT_RX_OVERRUN   = 4;
    localparam int unsigned STAT_RX_FRAME_ERR = 5;

    // Smallest clocks-per-bit the serial engines accept
    localparam logic [15:0] DIV_MIN = 16'd4;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Serial frame state, shared by the TX and RX engines
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Raise a requested divider to the supported minimum
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < DIV_MIN) ? DIV_MIN : value;
    endfunction

endpackage

// File: rtl/uart_lite_axi_if.sv
// AXI-Lite bus bundle with master and slave views.
interface AXI_LITE #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                  awprot;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                  arprot;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport Master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uart_lite_fifo.sv
// Byte FIFO for the transmit path: wrapping pointers plus an occupancy count,
// first-word fall-through read data.
module uart_lite_fifo
    import uart_lite_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [7:0]    mem_q [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; simultaneous push and pop cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    // Storage array, written on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_lite.sv
// AXI-Lite controlled 8N1 UART: register slave, TX FIFO + transmit engine,
// synchronised receive engine with a single-byte holding register.
module uart_lite
    import uart_lite_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned TX_FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_RESET      = 16'd868
) (
    input  logic  clk,
    input  logic  rst,
    AXI_LITE.Slave axi,
    output logic  tx,
    input  logic  rx
);
    // ---------------- register slave ----------------
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic                      wr_accept;
    logic                      rd_accept;
    logic                      wr_mapped;
    logic                      rd_mapped;
    logic [1:0]                wr_idx;
    logic [1:0]                rd_idx;

    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic [1:0]                bresp_d;
    logic                      rvalid_q;
    logic [1:0]                rresp_q;
    logic [1:0]                rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [31:0]               rdata_d;
    logic [15:0]               div_q;
    logic                      div_wr;
    logic [31:0]               status_w;
    logic                      rd_rx_clr;
    logic                      rd_stat_clr;

    // ---------------- TX path ----------------
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic        tx_q, tx_d;
    logic        tx_last;

    // ---------------- RX path ----------------
    logic        rx_meta_q;
    logic        rx_sync_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic        rx_last;
    logic        rx_half;
    logic        rx_done_ok;
    logic        rx_done_bad;
    logic [7:0]  rx_byte_q;
    logic        rx_valid_q;
    logic        rx_overrun_q;
    logic        rx_ferr_q;
    logic        rx_valid_eff;

    logic        unused_bits;

    assign awaddr    = axi.awaddr;
    assign araddr    = axi.araddr;
    assign wdata     = axi.wdata;
    assign wr_idx    = awaddr[3:2];
    assign rd_idx    = araddr[3:2];
    assign wr_mapped = (awaddr[11:4] == '0);
    assign rd_mapped = (araddr[11:4] == '0);

    assign wr_accept = !rst && axi.awvalid && axi.wvalid && !bvalid_q;
    assign rd_accept = !rst && axi.arvalid && !rvalid_q;

    assign axi.awready = wr_accept;
    assign axi.wready  = wr_accept;
    assign axi.arready = rd_accept;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rdata_q;
    assign tx          = tx_q;

    assign unused_bits = ^{awaddr, araddr, wdata, axi.wstrb, axi.awprot, axi.arprot};

    // Write decode: pick the side effect and the B response code
    always_comb begin
        fifo_push = 1'b0;
        div_wr    = 1'b0;
        bresp_d   = RESP_SLVERR;
        if (wr_accept && wr_mapped) begin
            case (wr_idx)
                REG_TXDATA: begin
                    if (!fifo_full) begin
                        fifo_push = 1'b1;
                        bresp_d   = RESP_OKAY;
                    end
                end
                REG_DIV: begin
                    div_wr  = 1'b1;
                    bresp_d = RESP_OKAY;
                end
                default: ;
            endcase
        end
    end

    // STATUS word assembly
    always_comb begin
        status_w                    = '0;
        status_w[STAT_TX_FULL]      = fifo_full;
        status_w[STAT_TX_EMPTY]     = fifo_empty;
        status_w[STAT_TX_BUSY]      = (tx_state_q != ST_IDLE);
        status_w[STAT_RX_VALID]     = rx_valid_q;
        status_w[STAT_RX_OVERRUN]   = rx_overrun_q;
        status_w[STAT_RX_FRAME_ERR] = rx_ferr_q;
    end

    // Read decode: data, response code and read-side clear strobes
    always_comb begin
        rresp_d     = RESP_SLVERR;
        rdata_d     = '0;
        rd_rx_clr   = 1'b0;
        rd_stat_clr = 1'b0;
        if (rd_mapped) begin
            case (rd_idx)
                REG_RXDATA: begin
                    rresp_d   = RESP_OKAY;
                    rdata_d   = {23'b0, rx_valid_q, rx_byte_q};
                    rd_rx_clr = rd_accept;
                end
                REG_STATUS: begin
                    rresp_d     = RESP_OKAY;
                    rdata_d     = status_w;
                    rd_stat_clr = rd_accept;
                end
                REG_DIV: begin
                    rresp_d = RESP_OKAY;
                    rdata_d = {16'b0, div_q};
                end
                default: ;
            endcase
        end
    end

    // AXI response channels and the divider register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
            rvalid_q <= 1'b0;
            rresp_q  <= '0;
            rdata_q  <= '0;
            div_q    <= DIV_RESET;
        end else begin
            if (wr_accept) begin
                bvalid_q <= 1'b1;
                bresp_q  <= bresp_d;
            end else if (axi.bready) begin
                bvalid_q <= 1'b0;
            end
            if (rd_accept) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rresp_d;
                rdata_q  <= AXI_DATA_WIDTH'(rdata_d);
            end else if (axi.rready) begin
                rvalid_q <= 1'b0;
            end
            if (div_wr) begin
                div_q <= clamp_div(wdata[15:0]);
            end
        end
    end

    uart_lite_fifo #(
        .DEPTH(TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (fifo_push),
        .data_i (wdata[7:0]),
        .pop_i  (fifo_pop),
        .data_o (fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign tx_last = (tx_cnt_q == tx_div_q - 16'd1);

    // TX next-state: frame sequencing, FIFO pop, divider latch; STOP chains straight into START
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_div_d   = tx_div_q;
        fifo_pop   = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_shift_d = fifo_rdata;
                    tx_div_d   = div_q;
                    tx_cnt_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_last) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (tx_last) begin
                    tx_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_shift_d = fifo_rdata;
                        tx_div_d   = div_q;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // TX state register; the line level is registered from the next state so it changes glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_div_q   <= DIV_RESET;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_div_q   <= tx_div_d;
            tx_q       <= tx_d;
        end
    end

    assign rx_last = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_half = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);

    // RX next-state: start validation at half a bit, then one sample per bit period
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_div_d    = rx_div_q;
        rx_done_ok  = 1'b0;
        rx_done_bad = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    rx_div_d   = div_q;
                    rx_cnt_d   = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_half) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (rx_last) begin
                    rx_cnt_d    = '0;
                    rx_done_ok  = rx_sync_q;
                    rx_done_bad = !rx_sync_q;
                    rx_state_d  = ST_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX synchroniser and state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_div_q   <= DIV_RESET;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_div_q   <= rx_div_d;
        end
    end

    // A same-cycle RXDATA read already empties the holding register, so an arriving byte is not an overrun
    assign rx_valid_eff = rx_valid_q && !rd_rx_clr;

    // Received-byte holding register and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            if (rx_done_ok && !rx_valid_eff) begin
                rx_byte_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (rd_rx_clr) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_done_ok && rx_valid_eff) begin
                rx_overrun_q <= 1'b1;
            end else if (rd_stat_clr) begin
                rx_overrun_q <= 1'b0;
            end
            if (rx_done_bad) begin
                rx_ferr_q <= 1'b1;
            end else if (rd_stat_clr) begin
                rx_ferr_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_lite.md
UART_LITE -- requirements
Module: uart_lite

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, AXI-Lite address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI-Lite data width; only 32 is supported.
REQ-003 SHALL have parameter TX_FIFO_DEPTH, default 8, TX FIFO entries, power of two, at least 2.
REQ-004 SHALL have parameter DIV_RESET, default 16'd868, reset clocks-per-bit.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port axi, AXI_LITE slave modport, AXI_ADDR_WIDTH/AXI_DATA_WIDTH: register access, fed by the AXI-to-AXI-Lite converter.
REQ-008 SHALL have port tx, output, 1 bit: serial out, 8N1, LSB first.
REQ-009 SHALL have port rx, input, 1 bit: asynchronous serial in, 8N1.

Function
REQ-010 Register map, decoded on addr[3:2], addr[11:4] required to be zero:
- 0x0 TXDATA, write-only: push wdata[7:0].
- 0x4 RXDATA, read-only: {23'b0, valid, byte}; a read clears valid.
- 0x8 STATUS, read-only: bit0 tx_full, bit1 tx_empty, bit2 tx_busy, bit3 rx_valid, bit4 rx_overrun, bit5 rx_frame_err; a read clears bits 4 and 5.
- 0xC DIV, read/write: [15:0] clocks per bit.
REQ-011 Write channel: AW and W SHALL be accepted together, only when both are valid and no B is pending (awready=wready=1 for that one cycle).
REQ-012 bvalid SHALL assert the cycle after acceptance and hold until bready.
REQ-013 Read channel: AR SHALL be accepted only when no R is pending; rvalid SHALL assert the next cycle and hold until rready, with rdata stable.
REQ-014 Read-side clears (REQ-010) SHALL occur at AR acceptance.
REQ-015 Response codes:
- SLVERR for an unmapped address, a write to RXDATA or STATUS, a read of TXDATA, or a TXDATA write while tx_full; data is dropped in each case.
- OKAY otherwise.
- Unmapped reads return 0.
REQ-016 A DIV write with a value below 4 SHALL store 4.
REQ-017 The TX FIFO SHALL use wrapping read/write pointers with a count of 0..TX_FIFO_DEPTH; tx_full = (count==DEPTH), tx_empty = (count==0).
REQ-018 A push and a pop in the same cycle SHALL leave count unchanged; full is evaluated on the registered count before the pop.
REQ-019 TX FSM states and transitions:
- IDLE to START when the FIFO is not empty: pop the byte and latch DIV.
- START, tx=0, for DIV cycles.
- DATA: 8 bits LSB first, DIV cycles each.
- STOP, tx=1, for DIV cycles, then IDLE.
- tx_busy = (state != IDLE).
- A DIV write mid-frame SHALL affect only the next frame.
REQ-020 Back-to-back TX: STOP SHALL go directly to START when the FIFO is non-empty, with no extra idle cycle.
REQ-021 RX input path: rx SHALL pass a 2-flop synchroniser; the FSM runs IDLE, START, DATA, STOP.
REQ-022 RX start detection: in IDLE, synchronised rx==0 enters START and latches DIV.
- At DIV/2 cycles, rx still 0 moves to DATA; otherwise return to IDLE (glitch rejected).
REQ-023 RX sampling: DATA samples 8 bits, one every DIV cycles, LSB first; STOP samples once more after DIV cycles.
REQ-024 RX frame completion:
- Stop bit 1 with valid=0: load the byte and set valid.
- Stop bit 1 with valid=1: keep the old byte and set rx_overrun.
- Stop bit 0: discard the byte and set rx_frame_err.
- Every case returns to IDLE.
REQ-025 Byte arrival and RXDATA read in the same cycle: the read returns the old byte; the new byte is loaded with valid=1, and no overrun is set.

Reset
REQ-026 While rst is high, the block SHALL hold:
- tx=1.
- awready=wready=arready=0, bvalid=rvalid=0.
- bresp, rresp, rdata = 0.
- Both FSMs in IDLE, FIFO empty (pointers and count 0).
- DIV=DIV_RESET.
- rx valid/overrun/frame_err=0; synchroniser flops=1.
REQ-027 Reset mid-frame SHALL abort both frames immediately (tx=1) and discard FIFO contents.

Structure
REQ-028 Register offsets, the STATUS bit indices, the DIV minimum (4) and the TX/RX state enum SHALL live in a shared package, uart_lite_pkg.
REQ-029 The TX FIFO SHALL be a separate sub-module, uart_lite_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty).

Verification
REQ-030 Reset tx path: DIV=4, write 0x0=0xA5 -> tx shows 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; B=OKAY.
REQ-031 TX FIFO overflow: write 9 bytes 0x00..0x08 back-to-back at DIV=1000 -> first 9 OKAY (byte 0 popped immediately, 8 in FIFO); a 10th write returns SLVERR, tx_full=1.
REQ-032 RX receive: drive 0x3C at DIV=8 -> STATUS bit3=1, RXDATA reads 0x13C, then the next read gives 0x03C.
REQ-033 RX overrun and framing:
- Two frames 0x11, 0x22 without an intervening read -> RXDATA=0x111, STATUS bit4=1, then bit4=0 on the next read.
- A frame with stop=0 -> bit5=1.
REQ-034 Glitch and DIV limit: a 1-cycle low pulse on rx at DIV=8 -> no byte, no error; DIV write of 2 -> reads back 4.
REQ-035 Reset mid-frame: assert rst during DATA of a TX frame -> tx=1 the same cycle, and STATUS reads 0x2 after release.
